// File: rtl/arb_txn_mux5.sv
// arb_txn_mux5: grant-driven burst sequencer between the 5-way arbiter and a shared memory port (optional stall timeout: ARB_TXN_MUX_TIMEOUT_EN)
module arb_txn_mux5 #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int LW = 8,
    parameter int TMO_CYC = 255
) (
    input  logic            CLK,
    input  logic            XRST,
    input  logic [4:0]      GNT,
    output logic            ACK,
    input  logic [5*AW-1:0] CH_ADDR,
    input  logic [5*LW-1:0] CH_LEN,
    input  logic [4:0]      CH_WE,
    input  logic [5*DW-1:0] CH_WDATA,
    output logic [4:0]      CH_BEAT,
    output logic [4:0]      CH_DONE,
    output logic [DW-1:0]   CH_RDATA,
    output logic            M_VALID,
    input  logic            M_READY,
    output logic [AW-1:0]   M_ADDR,
    output logic            M_WE,
    output logic [DW-1:0]   M_WDATA,
    input  logic [DW-1:0]   M_RDATA,
    output logic            BUSY,
    output logic            ERR
);
    typedef enum logic [1:0] {IDLE, BURST, DONE, WAIT} state_t;
    state_t        state, state_nx;
    logic [2:0]    idx, gnt_idx;
    logic [AW-1:0] addr;
    logic [LW-1:0] cnt;
    logic          we, beat, tmo;

    // lowest set grant bit wins, so a non-one-hot grant still selects one requester
    always_comb gnt_idx = GNT[0] ? 3'd0 : GNT[1] ? 3'd1 : GNT[2] ? 3'd2 : GNT[3] ? 3'd3 : 3'd4;

    assign beat = (state == BURST) && M_READY;

`ifdef ARB_TXN_MUX_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] stall;
    logic          err;
    // consecutive unaccepted beat requests; any accepted beat or leaving BURST clears it
    always_ff @(posedge CLK)
        if (!XRST || state != BURST || M_READY) stall <= '0;
        else stall <= stall + 1'b1;
    assign tmo = (state == BURST) && !M_READY && (stall == TW'(TMO_CYC - 1));
    // timeout flag stays set until reset
    always_ff @(posedge CLK)
        if (!XRST) err <= 1'b0;
        else if (tmo) err <= 1'b1;
    assign ERR = err;
`else
    assign tmo = 1'b0;
    assign ERR = 1'b0;
`endif

    // state register
    always_ff @(posedge CLK)
        if (!XRST) state <= IDLE;
        else state <= state_nx;

    // burst context: captured from the granted channel in IDLE, stepped on each accepted beat
    always_ff @(posedge CLK)
        if (!XRST) begin
            idx  <= '0;
            addr <= '0;
            cnt  <= '0;
            we   <= 1'b0;
        end else if (state == IDLE && |GNT) begin
            idx  <= gnt_idx;
            addr <= CH_ADDR[gnt_idx*AW +: AW];
            cnt  <= CH_LEN[gnt_idx*LW +: LW];
            we   <= CH_WE[gnt_idx];
        end else if (beat) begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 1'b1;
        end

    // next state: WAIT holds until the arbiter drops the grant so it is never re-latched
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |GNT ? BURST : IDLE;
            BURST:   state_nx = ((beat && cnt == '0) || tmo) ? DONE : BURST;
            DONE:    state_nx = WAIT;
            default: state_nx = (GNT == '0) ? IDLE : WAIT;
        endcase
    end

    // outputs decode from registered state only, so GNT never reaches the M_* port combinationally
    always_comb begin
        M_VALID  = state == BURST;
        M_ADDR   = addr;
        M_WE     = we;
        M_WDATA  = CH_WDATA[idx*DW +: DW];
        CH_BEAT  = beat ? 5'(5'd1 << idx) : 5'd0;
        ACK      = state == DONE;
        CH_DONE  = (state == DONE) ? 5'(5'd1 << idx) : 5'd0;
        CH_RDATA = M_RDATA;
        BUSY     = state != IDLE;
    end
endmodule

// File: tb/tb_arb_txn_mux5.sv
// tb_arb_txn_mux5: directed scoreboard bench for arb_txn_mux5
module tb_arb_txn_mux5;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 8;
`ifdef ARB_TXN_MUX_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic            CLK = 1'b0;
    logic            XRST;
    logic [4:0]      GNT;
    logic            ACK;
    logic [5*AW-1:0] CH_ADDR;
    logic [5*LW-1:0] CH_LEN;
    logic [4:0]      CH_WE;
    logic [5*DW-1:0] CH_WDATA;
    logic [4:0]      CH_BEAT;
    logic [4:0]      CH_DONE;
    logic [DW-1:0]   CH_RDATA;
    logic            M_VALID;
    logic            M_READY;
    logic [AW-1:0]   M_ADDR;
    logic            M_WE;
    logic [DW-1:0]   M_WDATA;
    logic [DW-1:0]   M_RDATA;
    logic            BUSY;
    logic            ERR;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } beat_t;

    beat_t q[$];
    int total = 0;
    int bad = 0;
    int nb = 0;
    int n;

    arb_txn_mux5 #(.AW(AW), .DW(DW), .LW(LW), .TMO_CYC(TMO)) dut (
        .CLK(CLK), .XRST(XRST), .GNT(GNT), .ACK(ACK),
        .CH_ADDR(CH_ADDR), .CH_LEN(CH_LEN), .CH_WE(CH_WE), .CH_WDATA(CH_WDATA),
        .CH_BEAT(CH_BEAT), .CH_DONE(CH_DONE), .CH_RDATA(CH_RDATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_ADDR(M_ADDR), .M_WE(M_WE),
        .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // requester data and port read data both advance with the global accepted-beat count
    task automatic drive_data();
        for (int c = 0; c < 5; c++) CH_WDATA[c*DW +: DW] = 16'hA000 | 16'(c << 8) | 16'(nb % 256);
        M_RDATA = 16'h5000 + 16'(nb);
    endtask

    task automatic cfg(input int ch, input logic [15:0] a, input logic [7:0] len, input logic w);
        CH_ADDR[ch*AW +: AW] = a;
        CH_LEN[ch*LW +: LW] = len;
        CH_WE[ch] = w;
    endtask

    task automatic push(input int ch, input logic [15:0] a, input int len, input logic w);
        beat_t b;
        for (int k = 0; k <= len; k++) begin
            b.ch = 3'(ch);
            b.addr = a + 16'(k);
            b.we = w;
            b.wdata = 16'hA000 | 16'(ch << 8) | 16'((nb + k) % 256);
            b.rdata = 16'h5000 + 16'(nb + k);
            q.push_back(b);
        end
    endtask

    // sample mid-cycle; every valid beat request is checked against the scoreboard head
    task automatic look();
        @(negedge CLK);
        if (M_VALID && q.size() == 0) chk("sb_unexpected_valid", M_VALID, 0);
        else if (M_VALID) begin
            chk("m_addr", M_ADDR, q[0].addr);
            chk("m_we", M_WE, q[0].we);
            chk("m_wdata", M_WDATA, q[0].wdata);
            if (M_READY) begin
                chk("ch_beat", CH_BEAT, 32'd1 << q[0].ch);
                chk("ch_rdata", CH_RDATA, q[0].rdata);
                q.delete(0);
                nb++;
            end else chk("ch_beat_stall", CH_BEAT, 0);
        end else chk("ch_beat_idle", CH_BEAT, 0);
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
        drive_data();
    endtask

    // run cycles with a ready pattern until ACK; returns the cycle index of ACK
    task automatic run(input logic [15:0] rdy, input int budget, output int ack_i);
        ack_i = -1;
        for (int i = 0; i < budget; i++) begin
            M_READY = (i < 16) ? rdy[i] : 1'b1;
            look();
            if (ACK) begin
                ack_i = i;
                break;
            end
            adv();
        end
        chk("ack_within_budget", ACK, 1);
    endtask

    initial begin
        XRST = 1'b0;
        GNT = 5'b00100;
        M_READY = 1'b1;
        CH_ADDR = '0;
        CH_LEN = '0;
        CH_WE = '0;
        CH_WDATA = '0;
        M_RDATA = '0;
        cfg(2, 16'h0010, 8'd3, 1'b1);
        drive_data();
        for (int i = 0; i < 3; i++) begin
            look();
            chk("rst_valid", M_VALID, 0);
            chk("rst_ack", ACK, 0);
            chk("rst_busy", BUSY, 0);
            chk("rst_ch_done", CH_DONE, 0);
            chk("rst_err", ERR, 0);
            adv();
        end
        XRST = 1'b1;
        push(2, 16'h0010, 3, 1'b1);
        look();
        chk("pre_latch_valid", M_VALID, 0);
        chk("pre_latch_busy", BUSY, 0);
        adv();
        run(16'hFFFF, 12, n);
        chk("ch2_ack_cycle", n, 4);
        chk("ch2_ch_done", CH_DONE, 5'b00100);
        chk("ch2_sb_empty", q.size(), 0);
        adv();
        GNT = 5'b00000;
        look();
        chk("ch2_ack_single", ACK, 0);
        chk("ch2_wait_busy", BUSY, 1);
        adv();
        look();
        chk("ch2_idle_busy", BUSY, 0);
        adv();

        cfg(4, 16'hFFFE, 8'd2, 1'b0);
        push(4, 16'hFFFE, 2, 1'b0);
        GNT = 5'b10000;
        look();
        chk("ch4_pre_valid", M_VALID, 0);
        adv();
        run(16'b10101, 12, n);
        chk("ch4_ack_cycle", n, 5);
        chk("ch4_ch_done", CH_DONE, 5'b10000);
        chk("ch4_sb_empty", q.size(), 0);
        adv();
        GNT = 5'b00000;
        look();
        adv();
        look();
        chk("ch4_idle_busy", BUSY, 0);
        adv();

        cfg(0, 16'h0100, 8'd0, 1'b1);
        cfg(1, 16'h0300, 8'd1, 1'b1);
        push(0, 16'h0100, 0, 1'b1);
        GNT = 5'b00001;
        look();
        adv();
        run(16'hFFFF, 8, n);
        chk("b2b_ch0_ack_cycle", n, 1);
        chk("b2b_ch0_done", CH_DONE, 5'b00001);
        adv();
        look();
        chk("b2b_no_double_ack", ACK, 0);
        chk("b2b_stale_valid", M_VALID, 0);
        chk("b2b_stale_busy", BUSY, 1);
        adv();
        GNT = 5'b00000;
        look();
        chk("b2b_gap_valid", M_VALID, 0);
        adv();
        GNT = 5'b00010;
        push(1, 16'h0300, 1, 1'b1);
        look();
        chk("b2b_latch_valid", M_VALID, 0);
        adv();
        run(16'hFFFF, 8, n);
        chk("b2b_ch1_ack_cycle", n, 2);
        chk("b2b_ch1_done", CH_DONE, 5'b00010);
        chk("b2b_sb_empty", q.size(), 0);
        adv();
        GNT = 5'b00000;
        look();
        adv();

        cfg(1, 16'h0200, 8'd3, 1'b1);
        cfg(3, 16'h0700, 8'd3, 1'b0);
        push(1, 16'h0200, 3, 1'b1);
        GNT = 5'b01010;
        M_READY = 1'b1;
        look();
        adv();
        look();
        chk("ill_first_valid", M_VALID, 1);
        adv();
        look();
        XRST = 1'b0;
        adv();
        look();
        chk("midrst_valid", M_VALID, 0);
        chk("midrst_ack", ACK, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_ch_done", CH_DONE, 0);
        chk("midrst_sb_left", q.size(), 2);
        q.delete();
        XRST = 1'b1;
        GNT = 5'b00000;
        adv();
        look();
        chk("post_rst_valid", M_VALID, 0);
        adv();

`ifdef ARB_TXN_MUX_TIMEOUT_EN
        cfg(0, 16'h0040, 8'd5, 1'b1);
        push(0, 16'h0040, 5, 1'b1);
        GNT = 5'b00001;
        M_READY = 1'b0;
        look();
        adv();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            look();
            if (ACK) break;
            if (M_VALID) n++;
            adv();
        end
        chk("tmo_valid_cycles", n, 4);
        chk("tmo_ack", ACK, 1);
        chk("tmo_ch_done", CH_DONE, 5'b00001);
        chk("tmo_err_set", ERR, 1);
        q.delete();
        adv();
        GNT = 5'b00000;
        look();
        adv();
        look();
        chk("tmo_err_sticky", ERR, 1);
        chk("tmo_idle_busy", BUSY, 0);
        XRST = 1'b0;
        adv();
        look();
        chk("tmo_err_cleared", ERR, 0);
        XRST = 1'b1;
        adv();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arb_txn_mux5.md
# arb_txn_mux5

Transaction sequencer that sits directly downstream of the 5-way round-robin arbiter. It consumes the registered one-hot grant, latches the winning requester's command, and runs a multi-beat burst on the shared memory-side port. It routes beat strobes, write data and read data between that requester and the port. When the burst completes it returns a single-cycle ACK so the arbiter releases the grant.

## Interface
- AW, 16, address width (M_ADDR, per-channel address)
- DW, 16, data width
- LW, 8, burst-length field width; burst = CH_LEN+1 beats
- TMO_CYC, 255, consecutive stall cycles before abort (used only with ARB_TXN_MUX_TIMEOUT_EN)

Ports:
- CLK  in  1  clock; all logic on rising edge
- XRST  in  1  synchronous, active-low reset
- GNT  in  5  one-hot grant from arbiter (registered, held until ACK)
- ACK  out  1  one-cycle pulse: burst finished, arbiter may release grant
- CH_ADDR  in  5*AW  per-channel start address, channel n at [n*AW +: AW]
- CH_LEN  in  5*LW  per-channel beats-minus-one
- CH_WE  in  5  per-channel write (1) / read (0)
- CH_WDATA  in  5*DW  per-channel write data for current beat
- CH_BEAT  out  5  beat accepted strobe for owning channel
- CH_DONE  out  5  one-cycle burst-complete pulse for owning channel
- CH_RDATA  out  DW  read data, valid with CH_BEAT on reads
- M_VALID  out  1  beat request to shared port
- M_READY  in  1  port accepts beat this cycle
- M_ADDR  out  AW  beat address
- M_WE  out  1  beat direction
- M_WDATA  out  DW  beat write data
- M_RDATA  in  DW  read data, valid in the M_VALID&M_READY cycle
- BUSY  out  1  state != IDLE
- ERR  out  1  sticky timeout flag (0 when macro absent)

## Operation
- States: IDLE, BURST, DONE, WAIT.
- IDLE: if GNT != 0, latch idx = lowest set bit of GNT. Also latch addr, remaining count = CH_LEN[idx], and we = CH_WE[idx]. Go to BURST. A non-one-hot GNT is resolved to its lowest set bit; no error is raised.
- BURST: M_VALID=1, M_ADDR=addr reg, M_WE=we reg. M_WDATA=CH_WDATA[idx] (combinational select; requester advances its data after each CH_BEAT).
  - Each M_VALID&M_READY cycle: CH_BEAT[idx]=1 (combinational), addr+1 modulo 2^AW (wraps silently), count-1.
  - Beat with count==0 accepted -> DONE.
- DONE: ACK=1 and CH_DONE[idx]=1 for exactly one cycle, then WAIT.
- WAIT: stay until GNT==0, then IDLE. This guarantees a stale grant is never re-latched.
- GNT is ignored in BURST and DONE; a grant change mid-burst does not affect the burst.
- CH_RDATA = M_RDATA always; CH_BEAT on non-owning channels is 0.
- Reset (XRST=0 at an edge, any state incl. mid-burst): state IDLE, M_VALID=0, ACK=0, CH_BEAT=0, CH_DONE=0, BUSY=0, ERR=0, addr/count/idx/we regs=0. The burst is abandoned with no ACK.

## Timing
- GNT first seen high at edge k -> M_VALID high from cycle k+1 (registered).
- Final beat accepted in cycle j -> ACK and CH_DONE high in cycle j+1 only.
- Arbiter drops GNT in cycle j+2; block returns to IDLE at edge ending j+2. A new grant can be latched from cycle j+3.
- A 1-beat burst with M_READY tied high: grant visible at cycle 0, beat at 1, ACK at 2, GNT low at 3.
- No combinational path from GNT to any M_* output.
- M_VALID, once high, stays high and M_ADDR/M_WE stay stable until M_READY (except timeout abort).

## Configuration
- ARB_TXN_MUX_TIMEOUT_EN defined: a stall counter increments each BURST cycle with M_VALID&~M_READY and clears on any accepted beat. On reaching TMO_CYC, M_VALID drops the next cycle and the FSM enters DONE. ACK and CH_DONE pulse normally; ERR sets and stays 1 until reset.
- Undefined: no counter; BURST waits on M_READY indefinitely; ERR tied 0.

## Test plan
- Reset: hold XRST=0 3 cycles with GNT=5'b00100 -> all outputs 0; after release the grant is latched only from the next edge.
- Grant ch2, CH_LEN=3, addr 0x0010, write, M_READY=1 -> M_ADDR 0x10..0x13 on 4 consecutive cycles, CH_BEAT=5'b00100 each. ACK and CH_DONE[2] pulse once the cycle after the 4th beat.
- Grant ch4, read, addr 0xFFFE, CH_LEN=2, M_READY toggling 1,0,1,0,1 -> 3 beats at 0xFFFE, 0xFFFF, 0x0000. CH_RDATA matches M_RDATA on beat cycles; M_ADDR is held during stall cycles.
- Back-to-back: ch0 then ch1 grants from the arbiter model -> no ACK double-pulse; second burst's M_VALID rises no earlier than 2 cycles after the first ACK.
- GNT=5'b01010 (illegal) -> ch1 served; XRST dropped mid-burst at beat 2 -> M_VALID=0 next cycle, no ACK.
- With ARB_TXN_MUX_TIMEOUT_EN, TMO_CYC=4, M_READY=0 -> M_VALID high 4 cycles, then ACK pulse, ERR=1 sticky until reset.
